seg_scan_reader: RTL and testbench

- Reverse direction of the display path: reads a multiplexed, active-low-strobed 7-segment bus (segment lines plus digit anodes) and recovers the 4-bit digit value shown on each position.
- Used to self-check display drive, or to read an external panel.
- Filters scan glitches with a stability window and keeps a per-digit value bank.
- Reports every value change as an event on a valid/ready stream.

---
 rtl/seg_scan_if.sv | 26 ++
 rtl/seg_scan_reader.sv | 165 ++++++++++++++++
 tb/tb_seg_scan_reader.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_if.sv
// Bundle of the scanned 7-segment bus, decoded value bank and event stream for seg_scan_reader.
// The master side drives the panel lines and the event consumer; the slave side is the reader.
interface seg_scan_if #(
    parameter int NDIG = 4
);
    logic [6:0]        seg;
    logic [NDIG-1:0]   an;
    logic [4*NDIG-1:0] digits;
    logic [NDIG-1:0]   derr;
    logic              ev_valid;
    logic              ev_ready;
    logic [2:0]        ev_idx;
    logic [3:0]        ev_digit;
    logic              ev_err;
    logic              ovf;

    modport master (
        output seg, an, ev_ready,
        input  digits, derr, ev_valid, ev_idx, ev_digit, ev_err, ovf
    );

    modport slave (
        input  seg, an, ev_ready,
        output digits, derr, ev_valid, ev_idx, ev_digit, ev_err, ovf
    );
endinterface

// File: rtl/seg_scan_reader.sv
// Recovers digit values from a multiplexed active-low-strobed 7-segment bus and reports changes as events.
// Optional macro SEG_HEX_EN adds the A..F glyphs to the decode table.
module seg_scan_reader #(
    parameter int NDIG       = 4,
    parameter int STABLE_CYC = 4
) (
    input  logic      clk,
    input  logic      rst,
    seg_scan_if.slave bus
);
    localparam int             CW   = $clog2(STABLE_CYC + 1);
    localparam logic [CW-1:0]  CMAX = CW'(STABLE_CYC);

    typedef enum logic [1:0] {IDLE, TRACK, HOLD} state_t;

    // Returns {err, value}
    function automatic logic [4:0] decode7(input logic [6:0] p);
        case (p)
            7'b0111111: return 5'h00;
            7'b0000110: return 5'h01;
            7'b1011011: return 5'h02;
            7'b1001111: return 5'h03;
            7'b1100110: return 5'h04;
            7'b1101101: return 5'h05;
            7'b1111101: return 5'h06;
            7'b0000111: return 5'h07;
            7'b1111111: return 5'h08;
            7'b1101111: return 5'h09;
`ifdef SEG_HEX_EN
            7'b1110111: return 5'h0A;
            7'b1111100: return 5'h0B;
            7'b0111001: return 5'h0C;
            7'b1011110: return 5'h0D;
            7'b1111001: return 5'h0E;
            7'b1110001: return 5'h0F;
`endif
            default:    return 5'h1F;
        endcase
    endfunction

    function automatic logic [2:0] low_idx(input logic [NDIG-1:0] a);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < NDIG; i++)
            if (!a[i]) r = 3'(i);
        return r;
    endfunction

    state_t            r_state, w_state_nx;
    logic [CW-1:0]     r_cnt, w_cnt_nx;
    logic [6:0]        r_seg_p0;
    logic [NDIG-1:0]   r_an_p0;
    logic [4*NDIG-1:0] r_digits;
    logic [NDIG-1:0]   r_derr;
    logic [NDIG-1:0]   r_seen;
    logic              r_ev_valid;
    logic [2:0]        r_ev_idx;
    logic [3:0]        r_ev_digit;
    logic              r_ev_err;
    logic              r_ovf;

    logic              w_in_valid;
    logic              w_same;
    logic              w_accept;
    logic [4:0]        w_dec;
    logic [4:0]        w_old;
    logic              w_seen_k;
    logic              w_new_ev;

    // Counter tracks how many consecutive identical samples the sample register now holds.
    assign w_in_valid = $onehot(~bus.an);
    assign w_same     = (bus.seg == r_seg_p0) && (bus.an == r_an_p0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_seg_p0 <= '0;
            r_an_p0  <= '0;
        end else begin
            r_state  <= w_state_nx;
            r_cnt    <= w_cnt_nx;
            r_seg_p0 <= bus.seg;
            r_an_p0  <= bus.an;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        if (!w_in_valid) begin
            w_state_nx = IDLE;
            w_cnt_nx   = '0;
        end else if (!w_same || r_state == IDLE) begin
            w_state_nx = TRACK;
            w_cnt_nx   = CW'(1);
        end else begin
            if (r_cnt != CMAX) w_cnt_nx = r_cnt + 1'b1;
            if (w_accept) w_state_nx = HOLD;
        end
    end

    always_comb begin
        w_accept = (r_state == TRACK) && (r_cnt == CMAX);
    end

    // ---- decode / compare against bank (sample stage) ----
    always_comb begin
        w_dec    = decode7(r_seg_p0);
        w_old    = '0;
        w_seen_k = 1'b0;
        for (int k = 0; k < NDIG; k++) begin
            if (!r_an_p0[k]) begin
                w_old    = {r_derr[k], r_digits[4*k +: 4]};
                w_seen_k = r_seen[k];
            end
        end
        w_new_ev = w_accept && (!w_seen_k || (w_old != w_dec));
    end

    // ---- bank and event stage ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_digits <= '0;
            r_derr   <= '0;
            r_seen   <= '0;
        end else if (w_accept) begin
            for (int k = 0; k < NDIG; k++) begin
                if (!r_an_p0[k]) begin
                    r_digits[4*k +: 4] <= w_dec[3:0];
                    r_derr[k]          <= w_dec[4];
                    r_seen[k]          <= 1'b1;
                end
            end
        end
    end

    // A slot frees up either when empty or when it transfers this cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ev_valid <= 1'b0;
            r_ev_idx   <= '0;
            r_ev_digit <= '0;
            r_ev_err   <= 1'b0;
            r_ovf      <= 1'b0;
        end else if (!r_ev_valid || bus.ev_ready) begin
            r_ev_valid <= w_new_ev;
            if (w_new_ev) begin
                r_ev_idx   <= low_idx(r_an_p0);
                r_ev_digit <= w_dec[3:0];
                r_ev_err   <= w_dec[4];
            end
        end else if (w_new_ev) begin
            r_ovf <= 1'b1;
        end
    end

    assign bus.digits   = r_digits;
    assign bus.derr     = r_derr;
    assign bus.ev_valid = r_ev_valid;
    assign bus.ev_idx   = r_ev_idx;
    assign bus.ev_digit = r_ev_digit;
    assign bus.ev_err   = r_ev_err;
    assign bus.ovf      = r_ovf;
endmodule

// File: tb/tb_seg_scan_reader.sv
// Directed testbench for seg_scan_reader (NDIG=4, STABLE_CYC=4); expected values are hand-computed.
module tb_seg_scan_reader;
    localparam int NDIG = 4;
`ifdef SEG_HEX_EN
    localparam logic [3:0] HEX_DIG = 4'hA;
    localparam logic       HEX_ERR = 1'b0;
`else
    localparam logic [3:0] HEX_DIG = 4'hF;
    localparam logic       HEX_ERR = 1'b1;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seg_scan_if #(.NDIG(NDIG)) bus();

    seg_scan_reader #(.NDIG(NDIG), .STABLE_CYC(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    // {idx[2:0], err, digit[3:0]} of every transfer seen on the event stream
    logic [7:0] evq[$];
    always @(negedge clk)
        if (!rst && bus.ev_valid && bus.ev_ready)
            evq.push_back({bus.ev_idx, bus.ev_err, bus.ev_digit});

    function automatic logic [6:0] p7(input int v);
        case (v)
            0: return 7'b0111111;
            1: return 7'b0000110;
            2: return 7'b1011011;
            3: return 7'b1001111;
            4: return 7'b1100110;
            5: return 7'b1101101;
            6: return 7'b1111101;
            7: return 7'b0000111;
            8: return 7'b1111111;
            default: return 7'b1101111;
        endcase
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] a, input logic [6:0] s, input int n);
        bus.an  = a;
        bus.seg = s;
        tick(n);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.ev_ready = 1'b0;
        bus.an  = 4'b1110;
        bus.seg = 7'b0111111;
        tick(3);
        checks++; if (bus.digits !== 16'h0) begin failures++; $display("FAIL rst_digits got=%h exp=%h", bus.digits, 16'h0); end
        checks++; if (bus.derr !== 4'h0) begin failures++; $display("FAIL rst_derr got=%h exp=%h", bus.derr, 4'h0); end
        checks++; if ({bus.ev_valid, bus.ev_idx, bus.ev_digit, bus.ev_err, bus.ovf} !== 10'h0) begin
            failures++; $display("FAIL rst_ev got=%b exp=0", {bus.ev_valid, bus.ev_idx, bus.ev_digit, bus.ev_err, bus.ovf}); end
        rst = 1'b0;
        tick(4);
        checks++; if (bus.ev_valid !== 1'b0) begin failures++; $display("FAIL rst_early_valid got=%b exp=0", bus.ev_valid); end
        tick(1);
        checks++; if (bus.ev_valid !== 1'b1) begin failures++; $display("FAIL rst_lat_valid got=%b exp=1", bus.ev_valid); end
        checks++; if ({bus.ev_idx, bus.ev_digit, bus.ev_err} !== 8'h0) begin
            failures++; $display("FAIL rst_lat_ev got=%h exp=0", {bus.ev_idx, bus.ev_digit, bus.ev_err}); end
        checks++; if (bus.digits[3:0] !== 4'h0) begin failures++; $display("FAIL rst_lat_dig got=%h exp=0", bus.digits[3:0]); end
        bus.ev_ready = 1'b1;
        tick(1);
        evq.delete();
    endtask

    task automatic test_scan;
        bus.ev_ready = 1'b1;
        drive(4'b1111, 7'b0, 2);
        evq.delete();
        for (int d = 0; d < 4; d++) drive(4'(~(4'b0001 << d)), p7(d + 1), 8);
        drive(4'b1111, 7'b0, 2);
        checks++; if (evq.size() !== 4) begin failures++; $display("FAIL scan_count got=%0d exp=4", evq.size()); end
        for (int i = 0; i < 4 && i < evq.size(); i++) begin
            checks++;
            if (evq[i] !== {3'(i), 1'b0, 4'(i + 1)}) begin
                failures++; $display("FAIL scan_ev%0d got=%h exp=%h", i, evq[i], {3'(i), 1'b0, 4'(i + 1)}); end
        end
        checks++; if (bus.digits !== 16'h4321) begin failures++; $display("FAIL scan_digits got=%h exp=4321", bus.digits); end
        evq.delete();
        for (int d = 0; d < 4; d++) drive(4'(~(4'b0001 << d)), p7(d + 1), 8);
        drive(4'b1111, 7'b0, 2);
        checks++; if (evq.size() !== 0) begin failures++; $display("FAIL rescan_count got=%0d exp=0", evq.size()); end
    endtask

    task automatic test_glitch;
        evq.delete();
        drive(4'b1011, p7(5), 3);
        drive(4'b1011, p7(6), 8);
        drive(4'b1111, 7'b0, 2);
        checks++; if (evq.size() !== 1) begin failures++; $display("FAIL glitch_count got=%0d exp=1", evq.size()); end
        if (evq.size() > 0) begin
            checks++; if (evq[0] !== {3'd2, 1'b0, 4'd6}) begin failures++; $display("FAIL glitch_ev got=%h exp=%h", evq[0], {3'd2, 1'b0, 4'd6}); end
        end
        checks++; if (bus.digits !== 16'h4621) begin failures++; $display("FAIL glitch_digits got=%h exp=4621", bus.digits); end
    endtask

    task automatic test_invalid;
        evq.delete();
        drive(4'b1101, 7'b1000000, 8);
        drive(4'b1111, 7'b0, 2);
        checks++; if (evq.size() !== 1) begin failures++; $display("FAIL inv_count got=%0d exp=1", evq.size()); end
        if (evq.size() > 0) begin
            checks++; if (evq[0] !== {3'd1, 1'b1, 4'hF}) begin failures++; $display("FAIL inv_ev got=%h exp=%h", evq[0], {3'd1, 1'b1, 4'hF}); end
        end
        checks++; if (bus.derr !== 4'b0010) begin failures++; $display("FAIL inv_derr got=%b exp=0010", bus.derr); end
        checks++; if (bus.digits !== 16'h46F1) begin failures++; $display("FAIL inv_digits got=%h exp=46F1", bus.digits); end
        evq.delete();
        drive(4'b1100, p7(8), 10);
        drive(4'b1111, 7'b0, 2);
        checks++; if (evq.size() !== 0) begin failures++; $display("FAIL overlap_count got=%0d exp=0", evq.size()); end
        checks++; if (bus.digits !== 16'h46F1) begin failures++; $display("FAIL overlap_digits got=%h exp=46F1", bus.digits); end
    endtask

    task automatic test_backpressure;
        bus.ev_ready = 1'b0;
        evq.delete();
        checks++; if (bus.ovf !== 1'b0) begin failures++; $display("FAIL bp_ovf_pre got=%b exp=0", bus.ovf); end
        drive(4'b0111, p7(7), 8);
        drive(4'b0111, p7(8), 8);
        drive(4'b1111, 7'b0, 2);
        checks++; if (bus.ev_valid !== 1'b1) begin failures++; $display("FAIL bp_valid got=%b exp=1", bus.ev_valid); end
        checks++; if ({bus.ev_idx, bus.ev_err, bus.ev_digit} !== {3'd3, 1'b0, 4'd7}) begin
            failures++; $display("FAIL bp_held got=%h exp=%h", {bus.ev_idx, bus.ev_err, bus.ev_digit}, {3'd3, 1'b0, 4'd7}); end
        checks++; if (bus.ovf !== 1'b1) begin failures++; $display("FAIL bp_ovf got=%b exp=1", bus.ovf); end
        checks++; if (bus.digits[15:12] !== 4'd8) begin failures++; $display("FAIL bp_digit got=%h exp=8", bus.digits[15:12]); end
        bus.ev_ready = 1'b1;
        tick(1);
        checks++; if (bus.ev_valid !== 1'b0) begin failures++; $display("FAIL bp_drain_valid got=%b exp=0", bus.ev_valid); end
        checks++; if (evq.size() !== 1 || evq[0] !== {3'd3, 1'b0, 4'd7}) begin
            failures++; $display("FAIL bp_xfer got_n=%0d exp_n=1 exp=%h", evq.size(), {3'd3, 1'b0, 4'd7}); end
        checks++; if (bus.ovf !== 1'b1) begin failures++; $display("FAIL bp_ovf_sticky got=%b exp=1", bus.ovf); end
    endtask

    task automatic test_hex;
        bus.ev_ready = 1'b1;
        evq.delete();
        drive(4'b1110, 7'b1110111, 8);
        drive(4'b1111, 7'b0, 2);
        checks++; if (evq.size() !== 1 || evq[0] !== {3'd0, HEX_ERR, HEX_DIG}) begin
            failures++; $display("FAIL hex_ev got_n=%0d exp_n=1 exp=%h", evq.size(), {3'd0, HEX_ERR, HEX_DIG}); end
        checks++; if (bus.digits[3:0] !== HEX_DIG || bus.derr[0] !== HEX_ERR) begin
            failures++; $display("FAIL hex_bank got=%h/%b exp=%h/%b", bus.digits[3:0], bus.derr[0], HEX_DIG, HEX_ERR); end
    endtask

    task automatic test_mid_reset;
        bus.ev_ready = 1'b0;
        drive(4'b1101, p7(9), 6);
        rst = 1'b1;
        #2;
        checks++; if ({bus.ev_valid, bus.ovf} !== 2'b00) begin failures++; $display("FAIL mrst_ctrl got=%b exp=00", {bus.ev_valid, bus.ovf}); end
        checks++; if (bus.digits !== 16'h0 || bus.derr !== 4'h0) begin
            failures++; $display("FAIL mrst_bank got=%h/%b exp=0/0", bus.digits, bus.derr); end
        tick(1);
        rst = 1'b0;
    endtask

    initial begin
        bus.ev_ready = 1'b0;
        bus.an  = 4'b1111;
        bus.seg = 7'b0;
        test_reset();
        test_scan();
        test_glitch();
        test_invalid();
        test_backpressure();
        test_hex();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
